phys_ram_responder: RTL and testbench
=====================================

PHYS_RAM_RESPONDER -- requirements
Module: phys_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter OOB_DATA, default 32'h0000_0000, value returned for out-of-range reads.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port phRamAddress  input  32  byte address from the initiator.
REQ-006 SHALL have port phRamOut  input  32  write data from the initiator.
REQ-007 SHALL have port phReadReq  input  1  read request, level.
REQ-008 SHALL have port phWriteReq  input  1  write request, level.
REQ-009 SHALL have port phRamIn  output  32  registered read data to the initiator.
REQ-010 SHALL have ports hostAddr input 32, hostWData input 32, hostWrite input 1, hostReq input 1, hostRData output 32, hostAck output 1: loader/debug port.
REQ-011 SHALL have ports oobErr output 1 (sticky) and oobCount output 8 (saturating).

Function
REQ-012 Word index = phRamAddress[log2(DEPTH_WORDS)+1:2]; bits [1:0] ignored; any nonzero bit above the index is out-of-range (OOB).
REQ-013 Read: at edge N where phReadReq=1, phRamIn <= word[index]; valid after N, held until next read edge; the initiator samples at edge N+1.
REQ-014 Write: at edge N where phWriteReq=1, word[index] <= phRamOut.
REQ-015 Both requests high: write performed, phRamIn gets the pre-write word (read-before-write).
REQ-016 Requests are levels with no handshake; a request held for several cycles re-executes each cycle (idempotent); an address change under a held request starts a new access that cycle.
REQ-017 No request: phRamIn holds its last value.
REQ-018 OOB read: phRamIn <= OOB_DATA; OOB write: discarded; either sets oobErr and increments oobCount, saturating at 8'hFF, once per cycle.
REQ-019 Host FSM states HIdle, HAccess, HAck: HIdle->HAccess on hostReq=1 (inputs captured); HAccess performs the read or write via the second array port, ->HAck; HAck drives hostAck=1 one cycle with hostRData valid, ->HIdle; hostReq must deassert before a new request is accepted.
REQ-020 Host port never delays ph accesses; same-word, same-cycle writes from both ports: ph write wins; host read of a word being ph-written returns the old value.
REQ-021 Host OOB access: write discarded, hostRData=OOB_DATA, oobErr/oobCount unaffected.

Reset
REQ-022 reset=0 asynchronously forces phRamIn=0, hostRData=0, hostAck=0, oobErr=0, oobCount=0, parityErr=0, host FSM to HIdle; array contents are not cleared.
REQ-023 Reset mid host transaction aborts it with no ack; a host write not yet in HAccess is not performed.

Configuration
REQ-024 With PHRAM_PARITY_EN defined: one even-parity bit stored per word on every write; ph reads check it; mismatch sets a sticky output parityErr (1 bit) and phRamIn still returns stored data.
REQ-025 Without PHRAM_PARITY_EN: no parity storage, no parityErr port.

Structure
REQ-026 Package phram_pkg SHALL hold DATA_W=32, the host FSM state enum, and the OOB counter width.
REQ-027 Storage SHALL be a sub-module phram_array: two synchronous ports, read-before-write, parity bit when enabled.

Verification
REQ-028 Write 32'hCAFEF00D at 0x100, read 0x100 next cycle -> phRamIn=32'hCAFEF00D after one edge.
REQ-029 Held read, address 0x200 then 0x204 on consecutive cycles (words 0x11, 0x22) -> phRamIn 0x11 then 0x22 on consecutive edges.
REQ-030 Read and write 0x55 at 0x300 (old 0x33) in the same cycle -> phRamIn=0x33; later read -> 0x55.
REQ-031 Read at 0x0010_0000 with DEPTH_WORDS=4096 -> phRamIn=OOB_DATA, oobErr=1, oobCount=1; 300 OOB cycles -> oobCount=8'hFF.
REQ-032 Host writes 0x77 at 0x40 while ph writes 0x99 at 0x40 same cycle -> word=0x99; hostAck one cycle, two edges after hostReq sampled.
REQ-033 PHRAM_PARITY_EN: force a stored parity bit flip, read word -> parityErr=1, stored data returned; reset -> parityErr=0.

Source files
------------

// File: rtl/phram_pkg.sv
// Shared types and constants for the physical RAM responder.
// Holds data width, OOB counter width, host FSM states, parity helper.
package phram_pkg;

  localparam int DATA_W    = 32;
  localparam int OOB_CNT_W = 8;

  typedef enum logic [1:0] {
    HIdle,
    HAccess,
    HAck
  } hostState_t;

  // Even parity: stored bit makes total ones count even.
  function automatic logic evenPar(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/phram_array.sv
// Dual-port word storage, synchronous read-before-write on both ports.
// Ports: clk, reset, port A (a*) and port B (b*) read/write, parityErr
// when PHRAM_PARITY_EN is defined (per-word even parity, checked on A).
module phram_array
  import phram_pkg::*;
#(
  parameter  int DEPTH_WORDS = 4096,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aRead,
  input  logic              aWrite,
  input  logic [AW-1:0]     aIdx,
  input  logic [DATA_W-1:0] aWData,
  output logic [DATA_W-1:0] aRData,
  input  logic              bRead,
  input  logic              bWrite,
  input  logic [AW-1:0]     bIdx,
  input  logic [DATA_W-1:0] bWData,
  output logic [DATA_W-1:0] bRData
`ifdef PHRAM_PARITY_EN
  ,
  output logic              parityErr
`endif
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Port A is written last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (bWrite) mem[bIdx] <= bWData;
    if (aWrite) mem[aIdx] <= aWData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aRData <= '0;
    end else if (aRead) begin
      aRData <= mem[aIdx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bRData <= '0;
    end else if (bRead) begin
      bRData <= mem[bIdx];
    end
  end

`ifdef PHRAM_PARITY_EN
  logic parMem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (bWrite) parMem[bIdx] <= evenPar(bWData);
    if (aWrite) parMem[aIdx] <= evenPar(aWData);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parityErr <= 1'b0;
    end else if (aRead) begin
      if (evenPar(mem[aIdx]) != parMem[aIdx]) parityErr <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/phys_ram_responder.sv
// Word RAM answering a level-request initiator plus a host loader port.
// Ports: clk, reset (async low), ph* initiator side, host* loader side,
// oobErr/oobCount; parityErr only when PHRAM_PARITY_EN is defined.
module phys_ram_responder
  import phram_pkg::*;
#(
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [DATA_W-1:0] OOB_DATA    = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    phRamAddress,
  input  logic [DATA_W-1:0]    phRamOut,
  input  logic                 phReadReq,
  input  logic                 phWriteReq,
  output logic [DATA_W-1:0]    phRamIn,
  input  logic [DATA_W-1:0]    hostAddr,
  input  logic [DATA_W-1:0]    hostWData,
  input  logic                 hostWrite,
  input  logic                 hostReq,
  output logic [DATA_W-1:0]    hostRData,
  output logic                 hostAck,
  output logic                 oobErr,
  output logic [OOB_CNT_W-1:0] oobCount
`ifdef PHRAM_PARITY_EN
  ,
  output logic                 parityErr
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Byte-lane bits carry no meaning for whole-word access.
  logic unusedBits;
  assign unusedBits = ^{phRamAddress[1:0], hostAddr[1:0]};

  logic [AW-1:0] phIdx;
  logic          phOob;
  logic          phOobQ;

  assign phIdx = phRamAddress[AW+1:2];
  assign phOob = |phRamAddress[DATA_W-1:AW+2];

  // Remember whether the last read was OOB to pick the return value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phOobQ <= 1'b0;
    end else if (phReadReq) begin
      phOobQ <= phOob;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oobErr   <= 1'b0;
      oobCount <= '0;
    end else if (phOob && (phReadReq || phWriteReq)) begin
      oobErr <= 1'b1;
      if (oobCount != '1) oobCount <= oobCount + 1'b1;
    end
  end

  hostState_t          state;
  hostState_t          stateNext;
  logic                hostHeld;
  logic                accept;
  logic [DATA_W-3:0]   hWordQ;
  logic [DATA_W-1:0]   hWDataQ;
  logic                hWriteQ;
  logic                hostOob;
  logic                hostOobQ;
  logic                bRead;
  logic                bWrite;
  logic [DATA_W-1:0]   aRData;
  logic [DATA_W-1:0]   bRData;

  assign hostOob = |hWordQ[DATA_W-3:AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HIdle;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    bRead     = 1'b0;
    bWrite    = 1'b0;
    hostAck   = 1'b0;
    unique case (state)
      HIdle: begin
        if (hostReq && !hostHeld) begin
          accept    = 1'b1;
          stateNext = HAccess;
        end
      end
      HAccess: begin
        bRead     = !hostOob;
        bWrite    = hWriteQ && !hostOob;
        stateNext = HAck;
      end
      HAck: begin
        hostAck   = 1'b1;
        stateNext = HIdle;
      end
      default: stateNext = HIdle;
    endcase
  end

  // A request still high after its ack must drop before re-arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hostHeld <= 1'b0;
    end else if (!hostReq) begin
      hostHeld <= 1'b0;
    end else if (accept) begin
      hostHeld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hWordQ  <= '0;
      hWDataQ <= '0;
      hWriteQ <= 1'b0;
    end else if (accept) begin
      hWordQ  <= hostAddr[DATA_W-1:2];
      hWDataQ <= hostWData;
      hWriteQ <= hostWrite;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hostOobQ <= 1'b0;
    end else if (state == HAccess) begin
      hostOobQ <= hostOob;
    end
  end

  phram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uArray (
    .clk      (clk),
    .reset    (reset),
    .aRead    (phReadReq && !phOob),
    .aWrite   (phWriteReq && !phOob),
    .aIdx     (phIdx),
    .aWData   (phRamOut),
    .aRData   (aRData),
    .bRead    (bRead),
    .bWrite   (bWrite),
    .bIdx     (hWordQ[AW-1:0]),
    .bWData   (hWDataQ),
    .bRData   (bRData)
`ifdef PHRAM_PARITY_EN
    ,
    .parityErr(parityErr)
`endif
  );

  assign phRamIn   = phOobQ ? OOB_DATA : aRData;
  assign hostRData = hostOobQ ? OOB_DATA : bRData;

endmodule

// File: tb/tb_phys_ram_responder.sv
// Self-checking bench for phys_ram_responder.
// Reference model: associative word store plus OOB counter arithmetic.
module tb_phys_ram_responder;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] OOBD  = 32'hBAD0_0BAD;

  logic        clk;
  logic        reset;
  logic [31:0] phRamAddress;
  logic [31:0] phRamOut;
  logic        phReadReq;
  logic        phWriteReq;
  logic [31:0] phRamIn;
  logic [31:0] hostAddr;
  logic [31:0] hostWData;
  logic        hostWrite;
  logic        hostReq;
  logic [31:0] hostRData;
  logic        hostAck;
  logic        oobErr;
  logic [7:0]  oobCount;
`ifdef PHRAM_PARITY_EN
  logic        parityErr;
`endif

  phys_ram_responder #(
    .DEPTH_WORDS(DEPTH),
    .OOB_DATA   (OOBD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .phRamAddress(phRamAddress),
    .phRamOut    (phRamOut),
    .phReadReq   (phReadReq),
    .phWriteReq  (phWriteReq),
    .phRamIn     (phRamIn),
    .hostAddr    (hostAddr),
    .hostWData   (hostWData),
    .hostWrite   (hostWrite),
    .hostReq     (hostReq),
    .hostRData   (hostRData),
    .hostAck     (hostAck),
    .oobErr      (oobErr),
    .oobCount    (oobCount)
`ifdef PHRAM_PARITY_EN
    ,
    .parityErr   (parityErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nCmp = 0;
  int          nBad = 0;
  logic [31:0] model [int];
  logic [31:0] expPh;
  int          expCnt;
  bit          expErr;

  function automatic bit isOob(input logic [31:0] a);
    return (a / (4 * DEPTH)) != 0;
  endfunction

  function automatic int wIdx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One initiator cycle; model updates reads before writes.
  task automatic phCycle(input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    phReadReq    = rd;
    phWriteReq   = wr;
    phRamAddress = a;
    phRamOut     = d;
    if (rd) begin
      if (isOob(a)) expPh = OOBD;
      else if (model.exists(wIdx(a))) expPh = model[wIdx(a)];
      else expPh = 32'h0;
    end
    if ((rd || wr) && isOob(a)) begin
      expErr = 1'b1;
      if (expCnt < 255) expCnt++;
    end
    if (wr && !isOob(a)) model[wIdx(a)] = d;
    tick();
    phReadReq  = 1'b0;
    phWriteReq = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #2;
    expCnt = 0;
    expErr = 1'b0;
    expPh  = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    nCmp++;
    if (phRamIn !== 32'h0) begin
      nBad++;
      $display("FAIL reset_phRamIn got %h want 0", phRamIn);
    end
    nCmp++;
    if (hostRData !== 32'h0) begin
      nBad++;
      $display("FAIL reset_hostRData got %h want 0", hostRData);
    end
    nCmp++;
    if (hostAck !== 1'b0) begin
      nBad++;
      $display("FAIL reset_hostAck got %b want 0", hostAck);
    end
    nCmp++;
    if (oobErr !== 1'b0 || oobCount !== 8'h0) begin
      nBad++;
      $display("FAIL reset_oob got %b/%h want 0/00", oobErr, oobCount);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    phCycle(0, 1, 32'h100, 32'hCAFE_F00D);
    phCycle(1, 0, 32'h100, 32'h0);
    nCmp++;
    if (phRamIn !== 32'hCAFE_F00D) begin
      nBad++;
      $display("FAIL basic_rd got %h want cafef00d", phRamIn);
    end
  endtask

  task automatic test_held_read();
    phCycle(0, 1, 32'h200, 32'h11);
    phCycle(0, 1, 32'h204, 32'h22);
    phCycle(1, 0, 32'h200, 32'h0);
    nCmp++;
    if (phRamIn !== 32'h11) begin
      nBad++;
      $display("FAIL held_rd0 got %h want 11", phRamIn);
    end
    phCycle(1, 0, 32'h204, 32'h0);
    nCmp++;
    if (phRamIn !== 32'h22) begin
      nBad++;
      $display("FAIL held_rd1 got %h want 22", phRamIn);
    end
    phRamAddress = 32'h100;
    tick();
    tick();
    nCmp++;
    if (phRamIn !== 32'h22) begin
      nBad++;
      $display("FAIL idle_hold got %h want 22", phRamIn);
    end
  endtask

  task automatic test_rbw();
    phCycle(0, 1, 32'h300, 32'h33);
    phCycle(1, 1, 32'h300, 32'h55);
    nCmp++;
    if (phRamIn !== 32'h33) begin
      nBad++;
      $display("FAIL rbw_old got %h want 33", phRamIn);
    end
    phCycle(1, 0, 32'h300, 32'h0);
    nCmp++;
    if (phRamIn !== 32'h55) begin
      nBad++;
      $display("FAIL rbw_new got %h want 55", phRamIn);
    end
  endtask

  task automatic test_host();
    hostAddr  = 32'h40;
    hostWData = 32'h77;
    hostWrite = 1'b1;
    hostReq   = 1'b1;
    tick();
    nCmp++;
    if (hostAck !== 1'b0) begin
      nBad++;
      $display("FAIL host_ack_early got %b want 0", hostAck);
    end
    phCycle(0, 1, 32'h40, 32'h99);
    nCmp++;
    if (hostAck !== 1'b1) begin
      nBad++;
      $display("FAIL host_ack got %b want 1", hostAck);
    end
    tick();
    nCmp++;
    if (hostAck !== 1'b0) begin
      nBad++;
      $display("FAIL host_ack_len got %b want 0", hostAck);
    end
    tick();
    tick();
    nCmp++;
    if (hostAck !== 1'b0) begin
      nBad++;
      $display("FAIL host_rearm got %b want 0", hostAck);
    end
    hostReq = 1'b0;
    tick();
    phCycle(1, 0, 32'h40, 32'h0);
    nCmp++;
    if (phRamIn !== 32'h99) begin
      nBad++;
      $display("FAIL host_collide got %h want 99", phRamIn);
    end
    hostAddr  = 32'h100;
    hostWrite = 1'b0;
    hostReq   = 1'b1;
    tick();
    hostReq = 1'b0;
    tick();
    nCmp++;
    if (hostAck !== 1'b1 || hostRData !== 32'hCAFE_F00D) begin
      nBad++;
      $display("FAIL host_rd got %b/%h want 1/cafef00d", hostAck, hostRData);
    end
    tick();
    hostAddr  = 32'h0010_0100;
    hostWData = 32'h1234;
    hostWrite = 1'b1;
    hostReq   = 1'b1;
    tick();
    hostReq = 1'b0;
    tick();
    nCmp++;
    if (hostRData !== OOBD) begin
      nBad++;
      $display("FAIL host_oob_data got %h want %h", hostRData, OOBD);
    end
    nCmp++;
    if (oobErr !== 1'b0 || oobCount !== 8'h0) begin
      nBad++;
      $display("FAIL host_oob_cnt got %b/%h want 0/00", oobErr, oobCount);
    end
    tick();
    phCycle(1, 0, 32'h100, 32'h0);
    nCmp++;
    if (phRamIn !== 32'hCAFE_F00D) begin
      nBad++;
      $display("FAIL host_oob_wr got %h want cafef00d", phRamIn);
    end
  endtask

  task automatic test_oob();
    phCycle(1, 0, 32'h0010_0000, 32'h0);
    nCmp++;
    if (phRamIn !== OOBD) begin
      nBad++;
      $display("FAIL oob_data got %h want %h", phRamIn, OOBD);
    end
    nCmp++;
    if (oobErr !== 1'b1 || oobCount !== 8'd1) begin
      nBad++;
      $display("FAIL oob_first got %b/%h want 1/01", oobErr, oobCount);
    end
    for (int i = 0; i < 299; i++) phCycle(1, 0, 32'h0010_0000, 32'h0);
    nCmp++;
    if (oobCount !== 8'hFF || expCnt != 255) begin
      nBad++;
      $display("FAIL oob_sat got %h want ff", oobCount);
    end
    phCycle(0, 1, 32'h0010_0100, 32'hDEAD);
    phCycle(1, 0, 32'h100, 32'h0);
    nCmp++;
    if (phRamIn !== 32'hCAFE_F00D) begin
      nBad++;
      $display("FAIL oob_wr_drop got %h want cafef00d", phRamIn);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          rd;
    bit          wr;
    doReset();
    for (int i = 0; i < 16; i++) phCycle(0, 1, 32'h1000 + 4 * i, $urandom);
    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = (32'h1 << (14 + $urandom_range(0, 17))) | ($urandom & 32'h3FFF);
      else
        a = 32'h1000 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      phCycle(rd, wr, a, $urandom);
      nCmp++;
      if (phRamIn !== expPh) begin
        nBad++;
        $display("FAIL rand_%0d got %h want %h", i, phRamIn, expPh);
      end
    end
    nCmp++;
    if (oobCount !== 8'(expCnt) || oobErr !== expErr) begin
      nBad++;
      $display("FAIL rand_oob got %b/%h want %b/%h",
               oobErr, oobCount, expErr, 8'(expCnt));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    old       = model[wIdx(32'h1000)];
    hostAddr  = 32'h1000;
    hostWData = ~old;
    hostWrite = 1'b1;
    hostReq   = 1'b1;
    tick();
    #2;
    reset   = 1'b0;
    hostReq = 1'b0;
    #1;
    nCmp++;
    if (hostAck !== 1'b0 || oobCount !== 8'h0 || phRamIn !== 32'h0) begin
      nBad++;
      $display("FAIL mid_reset got %b/%h/%h want 0/00/0",
               hostAck, oobCount, phRamIn);
    end
    expCnt = 0;
    expErr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    tick();
    nCmp++;
    if (hostAck !== 1'b0) begin
      nBad++;
      $display("FAIL mid_noack got %b want 0", hostAck);
    end
    phCycle(1, 0, 32'h1000, 32'h0);
    nCmp++;
    if (phRamIn !== old) begin
      nBad++;
      $display("FAIL mid_nowrite got %h want %h", phRamIn, old);
    end
  endtask

`ifdef PHRAM_PARITY_EN
  task automatic test_parity();
    phCycle(0, 1, 32'h500, 32'h5);
    phCycle(1, 0, 32'h500, 32'h0);
    nCmp++;
    if (parityErr !== 1'b0) begin
      nBad++;
      $display("FAIL par_clean got %b want 0", parityErr);
    end
    dut.uArray.parMem[12'h140] = ~dut.uArray.parMem[12'h140];
    phCycle(1, 0, 32'h500, 32'h0);
    nCmp++;
    if (parityErr !== 1'b1 || phRamIn !== 32'h5) begin
      nBad++;
      $display("FAIL par_err got %b/%h want 1/5", parityErr, phRamIn);
    end
    doReset();
    nCmp++;
    if (parityErr !== 1'b0) begin
      nBad++;
      $display("FAIL par_reset got %b want 0", parityErr);
    end
  endtask
`endif

  initial begin
    reset        = 1'b0;
    phRamAddress = 32'h0;
    phRamOut     = 32'h0;
    phReadReq    = 1'b0;
    phWriteReq   = 1'b0;
    hostAddr     = 32'h0;
    hostWData    = 32'h0;
    hostWrite    = 1'b0;
    hostReq      = 1'b0;
    expPh        = 32'h0;
    expCnt       = 0;
    expErr       = 1'b0;
    test_reset();
    test_basic();
    test_held_read();
    test_rbw();
    test_host();
    test_oob();
    test_random();
    test_reset_mid();
`ifdef PHRAM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
